fetch_unit: RTL

- Y86-64 sequential fetch stage, directly upstream of PC update.
- On a start pulse, reads the instruction at PC from byte-wide instruction memory over a req/ack handshake, one byte per transfer.
- Splits the instruction into icode/ifun/rA/rB/valC and computes valP for the downstream stages and PC update.
- Also flags invalid instructions and memory faults/timeouts.

---
 rtl/fetch_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Y86-64 fetch stage: reads one instruction a byte at a time over a req/ack
// port, splits it into icode/ifun/rA/rB/valC and computes valP.
module fetch_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] pc,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_err,
  output logic        busy,
  output logic        done,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_invalid,
  output logic        imem_error
);

  typedef enum logic [1:0] {IDLE, BYTE0, REST, DONE} state_t;

  localparam int          TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [63:0]   addr_q, addr_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    len_q, len_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    icode_q, icode_d, ifun_q, ifun_d;
  logic [3:0]    ra_q, ra_d, rb_q, rb_d;
  logic [63:0]   valc_q, valc_d, valp_q, valp_d;
  logic          inv_q, inv_d, ierr_q, ierr_d;

  logic          ack_ok, fault;
  logic [3:0]    byte0_len, cidx;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  // An ack in the expiring cycle still counts as a good transfer.
  assign ack_ok    = mem_req & mem_ack & ~mem_err;
  assign fault     = mem_req & ((mem_ack & mem_err) | (~mem_ack & (tmo_q == TMO_LAST)));
  assign byte0_len = instr_len(mem_rdata[7:4]);
  assign cidx      = idx_q - ((len_q == 4'd9) ? 4'd1 : 4'd2);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = BYTE0;
      BYTE0: begin
        if (fault)       state_d = DONE;
        else if (ack_ok) state_d = (byte0_len == 4'd1) ? DONE : REST;
      end
      REST: begin
        if (fault)                                 state_d = DONE;
        else if (ack_ok && idx_q == len_q - 4'd1)  state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    mem_req = (state_q == BYTE0) || (state_q == REST);
    busy    = mem_req;
    done    = (state_q == DONE);
  end

  always_comb begin
    pc_d    = pc_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    inv_d   = inv_q;
    ierr_d  = ierr_q;
    if (state_q == IDLE && start) begin
      pc_d    = pc;
      addr_d  = pc;
      idx_d   = 4'd0;
      len_d   = 4'd1;
      tmo_d   = '0;
      icode_d = 4'h0;
      ifun_d  = 4'h0;
      ra_d    = 4'hF;
      rb_d    = 4'hF;
      valc_d  = '0;
      valp_d  = pc;
      inv_d   = 1'b0;
      ierr_d  = 1'b0;
    end else if (mem_req) begin
      if (ack_ok) begin
        addr_d = addr_q + 64'd1;
        idx_d  = idx_q + 4'd1;
        tmo_d  = '0;
        if (state_q == BYTE0) begin
          icode_d = mem_rdata[7:4];
          ifun_d  = mem_rdata[3:0];
          len_d   = byte0_len;
          inv_d   = (mem_rdata[7:4] > 4'hB);
          valp_d  = pc_q + 64'(byte0_len);
        end else if (idx_q == 4'd1 && len_q != 4'd9) begin
          ra_d = mem_rdata[7:4];
          rb_d = mem_rdata[3:0];
        end else begin
          valc_d[8*cidx[2:0] +: 8] = mem_rdata;
        end
      end else if (fault) begin
        ierr_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      len_q   <= 4'd1;
      tmo_q   <= '0;
      icode_q <= '0;
      ifun_q  <= '0;
      ra_q    <= 4'hF;
      rb_q    <= 4'hF;
      valc_q  <= '0;
      valp_q  <= '0;
      inv_q   <= 1'b0;
      ierr_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      inv_q   <= inv_d;
      ierr_q  <= ierr_d;
    end
  end

  assign mem_addr      = addr_q;
  assign icode         = icode_q;
  assign ifun          = ifun_q;
  assign rA            = ra_q;
  assign rB            = rb_q;
  assign valC          = valc_q;
  assign valP          = valp_q;
  assign instr_invalid = inv_q;
  assign imem_error    = ierr_q;

endmodule
